// File: rtl/keyb_matrix_emulator.sv
// keyb_matrix_emulator: turns mapped key codes from the keyboard decoder into
// timed presses on an emulated 3-row x 6-column, active-low switch matrix.
// Each press is held for HOLD_CYCLES and followed by GAP_CYCLES of release.
// Build option: define KEYB_MATRIX_FIFO_EN for a FIFO_DEPTH-entry key queue;
// otherwise a single holding register queues one key.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for a queued key
// PRESS   | active key's switch closed, hold timer running
// GAP     | forced release, gap timer running
module keyb_matrix_emulator #(
  parameter int HOLD_CYCLES = 500000,
  parameter int GAP_CYCLES  = 250000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_keyb_value,
  input  logic [5:0] i_mat_col,
  output logic [2:0] o_mat_row,
  output logic       o_key_busy,
  output logic       o_key_overflow
);

`ifdef KEYB_MATRIX_FIFO_EN
  localparam int QD = FIFO_DEPTH;
`else
  // single holding register; FIFO_DEPTH has no effect in this build
  localparam int QD = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
  localparam int PW   = (QD > 1) ? $clog2(QD) : 1;
  localparam int QA   = 1 << PW;
  localparam int NW   = $clog2(QD + 1);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(QD - 1);
  localparam logic [NW-1:0] Q_FULL   = NW'(QD);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]    r_active, w_active_nxt;
  logic [5:0]    r_prev;
  logic [5:0]    r_q [QA];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [NW-1:0] r_count;
  logic [2:0]    r_row;
  logic          r_busy, r_ovf;

  logic w_empty, w_full, w_new_key, w_push_req, w_push, w_pop, w_drop;
  logic [5:0] w_km1, w_col, w_rowi;
  logic       w_sel;
  logic [2:0] w_row_nxt;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == Q_FULL);
  assign w_new_key  = (i_keyb_value != 6'd0) && (i_keyb_value != r_prev);
  assign w_push_req = w_new_key && (i_keyb_value <= 6'd18);
  // a pop on the same edge frees the slot, so a full queue still accepts
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign w_km1  = r_active - 6'd1;
  assign w_col  = w_km1 / 6'd3;
  assign w_rowi = w_km1 % 6'd3;

  // next-state, timer and pop decision
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_active_nxt = r_active;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_active_nxt = r_q[r_rd_ptr];
          w_cnt_nxt    = HOLD_LD;
          w_state_nxt  = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = GAP_LD;
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // row return for the active key's switch when its column is driven low
  always_comb begin
    w_sel = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (w_col == 6'(c)) w_sel = ~i_mat_col[c];
    end
    w_row_nxt = 3'b111;
    for (int r = 0; r < 3; r++) begin
      if ((r_state == ST_PRESS) && w_sel && (w_rowi == 6'(r))) w_row_nxt[r] = 1'b0;
    end
  end

  // FSM state, timer and active code registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_active <= 6'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_active <= w_active_nxt;
    end
  end

  // key queue storage and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wr_ptr] <= i_keyb_value;
        r_wr_ptr      <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // registered outputs and key edge history
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row  <= 3'b111;
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
      r_prev <= 6'd0;
    end else begin
      r_row  <= w_row_nxt;
      r_busy <= (r_state != ST_IDLE) || !w_empty;
      r_prev <= i_keyb_value;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign o_mat_row      = r_row;
  assign o_key_busy     = r_busy;
  assign o_key_overflow = r_ovf;

endmodule

// File: tb/tb_keyb_matrix_emulator.sv
// Bench for keyb_matrix_emulator: directed scenarios plus random traffic,
// compared every cycle against a time-based press schedule model.
module tb_keyb_matrix_emulator;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
`ifdef KEYB_MATRIX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] kv  = 6'd0;
  logic [5:0] col = 6'h3f;
  logic [2:0] row;
  logic       busy, ovf;

  always #5 clk = ~clk;

  keyb_matrix_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_keyb_value(kv), .i_mat_col(col),
    .o_mat_row(row), .o_key_busy(busy), .o_key_overflow(ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: a press popped at edge P is closed for edges P+1..P+HOLD and
  // the engine is occupied through edge P+HOLD+GAP
  int         cyc = 0;
  int         q[$];
  int         m_log[$];
  logic [2:0] m_row = 3'b111;
  bit         m_busy = 1'b0, m_ovf = 1'b0;
  int         m_prev = 0, m_act = 0, m_pop = -100000;
  bit         m_press, m_eng;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_row = 3'b111; m_busy = 1'b0; m_ovf = 1'b0;
      m_prev = 0; m_act = 0; m_pop = -100000;
    end else begin
      m_press = (cyc >= m_pop + 1) && (cyc <= m_pop + HOLD);
      m_eng   = (cyc >= m_pop + 1) && (cyc <= m_pop + HOLD + GAP);
      m_busy  = m_eng || (q.size() > 0);
      m_row   = 3'b111;
      if (m_press && col[(m_act - 1) / 3] == 1'b0) m_row[(m_act - 1) % 3] = 1'b0;
      if (!m_eng && q.size() > 0) begin
        m_act = q.pop_front();
        m_pop = cyc;
        m_log.push_back(m_act);
      end
      if (kv != 0 && int'(kv) != m_prev && kv <= 18) begin
        if (q.size() < DEPTH) q.push_back(int'(kv));
        else m_ovf = 1'b1;
      end
      m_prev = int'(kv);
    end
  end

  bit         chk_en = 1'b0;
  logic [2:0] prev_row = 3'b111;
  int         low_cnt = 0, press_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("row", int'(row), int'(m_row));
      chk("busy", int'(busy), int'(m_busy));
      chk("overflow", int'(ovf), int'(m_ovf));
      if (row != 3'b111) low_cnt++;
      if (row != 3'b111 && prev_row == 3'b111) press_cnt++;
      prev_row = row;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      step(1);
      k++;
    end
    if (k >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, k);
    end
    step(2);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    int target, guard, r;
    step(3);
    chk("reset_row", int'(row), 7);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ovf", int'(ovf), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // single press, column selected, first low row two edges after sampling
    col = 6'b111101; low_cnt = 0; press_cnt = 0; m_log.delete();
    kv = 6'd5;
    step(2);
    chk("A_before", int'(row), 7);
    step(1);
    chk("A_first_low", int'(row), 5);
    step(47);
    kv = 6'd0;
    wait_idle("A_idle");
    chk("A_low_cycles", low_cnt, HOLD);
    chk("A_presses", press_cnt, 1);
    chk("A_log_size", m_log.size(), 1);

    // wrong column, then switched mid-press
    col = 6'b111110; low_cnt = 0;
    kv = 6'd5;
    step(4);
    col = 6'b111101;
    step(20);
    kv = 6'd0;
    wait_idle("B_idle");
    chk("B_low_cycles", low_cnt, 6);

    // burst 1..6 with zeros between
    col = 6'b000000; m_log.delete(); press_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      kv = 6'(k);
      step(1);
      kv = 6'd0;
      step(1);
    end
    wait_idle("C_idle");
    chk("C_presses", press_cnt, DEPTH + 1);
    chk("C_ovf", int'(ovf), 1);
    chk("C_log_size", m_log.size(), DEPTH + 1);
    for (int i = 0; i < m_log.size(); i++) chk("C_log_order", m_log[i], i + 1);

    pulse_reset();
    chk("rst_ovf_clear", int'(ovf), 0);

    // direct transitions 18 -> 1 -> 20
    m_log.delete(); press_cnt = 0;
    kv = 6'd18; step(1);
    kv = 6'd1;  step(1);
    kv = 6'd20; step(3);
    kv = 6'd0;
    wait_idle("D_idle");
    chk("D_presses", press_cnt, 2);
    chk("D_ovf", int'(ovf), 0);
    chk("D_log_size", m_log.size(), 2);
    if (m_log.size() == 2) begin
      chk("D_first", m_log[0], 18);
      chk("D_second", m_log[1], 1);
    end

    // reset during a press with a key queued
    kv = 6'd3; step(1);
    kv = 6'd4; step(4);
    rst = 1'b1;
    step(1);
    chk("E_row_after_rst", int'(row), 7);
    chk("E_busy_after_rst", int'(busy), 0);
    rst = 1'b0;
    m_log.delete(); press_cnt = 0;
    step(30);
    wait_idle("E_idle");
    kv = 6'd0;
    step(1);
    chk("E_presses", press_cnt, 1);
    chk("E_log_size", m_log.size(), 1);
    if (m_log.size() == 1) chk("E_code", m_log[0], 4);

    // keys arriving during a press
    pulse_reset();
    m_log.delete(); press_cnt = 0;
    kv = 6'd7;  step(1); kv = 6'd0; step(1);
    kv = 6'd9;  step(1); kv = 6'd0; step(1);
    kv = 6'd11; step(1); kv = 6'd0;
    wait_idle("F_idle");
    chk("F_presses", press_cnt, (DEPTH > 1) ? 3 : 2);
    chk("F_ovf", int'(ovf), (DEPTH > 1) ? 0 : 1);

    // push landing on the same edge as a pop from a full queue
    pulse_reset();
    m_log.delete();
    for (int k = 1; k <= DEPTH + 1; k++) begin
      kv = 6'(k);
      step(1);
      kv = 6'd0;
      step(1);
    end
    target = m_pop + HOLD + GAP + 1;
    guard = 0;
    while (cyc < target - 1 && guard < 100) begin
      step(1);
      guard++;
    end
    kv = 6'd12;
    step(1);
    kv = 6'd0;
    chk("G_no_drop", int'(ovf), 0);
    wait_idle("G_idle");
    chk("G_log_size", m_log.size(), DEPTH + 2);
    if (m_log.size() > 0) chk("G_last", m_log[m_log.size() - 1], 12);

    // random traffic
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      kv = kv;
      else if (r < 75) kv = 6'd0;
      else if (r < 93) kv = 6'($urandom_range(1, 18));
      else             kv = 6'($urandom_range(19, 63));
      col = 6'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    kv = 6'd0;
    wait_idle("R_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
